// File: rtl/jtcop_bank_arb_if.sv
// Bus bundle between the bank slot muxes / ROM download port, the bank arbiter and the SDRAM core.
// The master modport is the arbiter's view; slave is the environment around it.
interface jtcop_bank_arb_if #(
  parameter int unsigned AW = 22
);
  logic          downloading;
  logic [3:0]    ba_rd;
  logic          ba_wr;
  logic [AW-1:0] ba0_addr;
  logic [AW-1:0] ba1_addr;
  logic [AW-1:0] ba2_addr;
  logic [AW-1:0] ba3_addr;
  logic [15:0]   ba0_din;
  logic [1:0]    ba0_din_m;
  logic [3:0]    ba_ack;
  logic [3:0]    ba_dst;
  logic [3:0]    ba_rdy;
  logic          prog_we;
  logic          prog_rd;
  logic [AW-1:0] prog_addr;
  logic [1:0]    prog_ba;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic          prog_ack;
  logic          prog_rdy;
  logic          sd_req;
  logic          sd_we;
  logic [1:0]    sd_ba;
  logic [AW-1:0] sd_addr;
  logic [15:0]   sd_din;
  logic [1:0]    sd_mask;
  logic          sd_rfsh;
  logic          sd_gnt;
  logic          sd_dst;
  logic          sd_rdy;

  modport master (
    input  downloading, ba_rd, ba_wr, ba0_addr, ba1_addr, ba2_addr, ba3_addr,
           ba0_din, ba0_din_m, prog_we, prog_rd, prog_addr, prog_ba, prog_data,
           prog_mask, sd_gnt, sd_dst, sd_rdy,
    output ba_ack, ba_dst, ba_rdy, prog_ack, prog_rdy, sd_req, sd_we, sd_ba,
           sd_addr, sd_din, sd_mask, sd_rfsh
  );

  modport slave (
    output downloading, ba_rd, ba_wr, ba0_addr, ba1_addr, ba2_addr, ba3_addr,
           ba0_din, ba0_din_m, prog_we, prog_rd, prog_addr, prog_ba, prog_data,
           prog_mask, sd_gnt, sd_dst, sd_rdy,
    input  ba_ack, ba_dst, ba_rdy, prog_ack, prog_rdy, sd_req, sd_we, sd_ba,
           sd_addr, sd_din, sd_mask, sd_rfsh
  );
endinterface

// File: rtl/jtcop_bank_arb.sv
// SDRAM bank arbiter: round-robin over four bank channels, auto-refresh insertion, download takeover.
// Define JTCOP_BANK0_PRIO_EN to give bank 0 absolute priority over banks 1-3.
module jtcop_bank_arb #(
  parameter int unsigned RFSH_CYCLES = 384,
  parameter int unsigned AW          = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtcop_bank_arb_if.master      bus
);
  localparam int unsigned CW = $clog2(RFSH_CYCLES);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RFSH} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] rfsh_cnt;
  logic          rfsh_pend;
  logic          rfsh_gnted;
  logic [1:0]    ptr;
  logic [1:0]    gnt_ba;
  logic          gnt_prog;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [15:0]   lat_din;
  logic [1:0]    lat_mask;

  logic [3:0]    active;
  logic          pick_vld;
  logic [1:0]    pick;
  logic [1:0]    cand;
  logic [AW-1:0] pick_addr;
  logic          prog_go;
  logic          bank_go;
  logic          done;
  logic          hit_ack, hit_dst, hit_rdy;

  assign active  = {bus.ba_rd[3:1], bus.ba_rd[0] | bus.ba_wr};
  assign prog_go = bus.downloading && (bus.prog_we || bus.prog_rd);
  assign bank_go = !bus.downloading && pick_vld;
  assign done    = (state == WAIT && bus.sd_rdy) ||
                   (state == CMD && bus.sd_gnt && bus.sd_rdy);

  // First active bank scanning cyclically from the pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick     = ptr;
    cand     = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = 2'(ptr + 2'(i));
      if (!pick_vld && active[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
`ifdef JTCOP_BANK0_PRIO_EN
    if (active[0]) begin
      pick_vld = 1'b1;
      pick     = 2'd0;
    end
`endif
  end

  always_comb begin
    pick_addr = bus.ba0_addr;
    case (pick)
      2'd0: pick_addr = bus.ba0_addr;
      2'd1: pick_addr = bus.ba1_addr;
      2'd2: pick_addr = bus.ba2_addr;
      2'd3: pick_addr = bus.ba3_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rfsh_cnt   <= CW'(RFSH_CYCLES - 1);
      rfsh_pend  <= 1'b0;
      rfsh_gnted <= 1'b0;
      ptr        <= '0;
      gnt_ba     <= '0;
      gnt_prog   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_din    <= '0;
      lat_mask   <= '0;
    end else begin
      state <= state_nx;

      // Completion clears first so an expiry in the same cycle still queues one refresh.
      if (state == RFSH && bus.sd_rdy)
        rfsh_pend <= 1'b0;
      if (rfsh_cnt == '0) begin
        rfsh_cnt  <= CW'(RFSH_CYCLES - 1);
        rfsh_pend <= 1'b1;
      end else begin
        rfsh_cnt <= rfsh_cnt - 1'b1;
      end

      if (state != RFSH)
        rfsh_gnted <= 1'b0;
      else if (bus.sd_gnt)
        rfsh_gnted <= 1'b1;

      if (state == IDLE && !rfsh_pend) begin
        if (prog_go) begin
          gnt_prog <= 1'b1;
          gnt_ba   <= bus.prog_ba;
          lat_we   <= bus.prog_we;
          lat_addr <= bus.prog_addr;
          lat_din  <= bus.prog_data;
          lat_mask <= bus.prog_mask;
        end else if (bank_go) begin
          gnt_prog <= 1'b0;
          gnt_ba   <= pick;
          lat_we   <= (pick == 2'd0) && bus.ba_wr;
          lat_addr <= pick_addr;
          lat_din  <= bus.ba0_din;
          lat_mask <= bus.ba0_din_m;
        end
      end

      if (done && !gnt_prog)
        ptr <= gnt_ba + 2'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (rfsh_pend)
          state_nx = RFSH;
        else if (prog_go || bank_go)
          state_nx = CMD;
      end
      CMD:  if (bus.sd_gnt) state_nx = bus.sd_rdy ? IDLE : WAIT;
      WAIT: if (bus.sd_rdy) state_nx = IDLE;
      RFSH: if (bus.sd_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    hit_ack = (state == CMD) && bus.sd_gnt;
    hit_dst = (state == WAIT) && bus.sd_dst;
    hit_rdy = done;

    bus.sd_req   = (state == CMD);
    bus.sd_rfsh  = (state == RFSH) && !rfsh_gnted;
    bus.sd_we    = lat_we;
    bus.sd_ba    = gnt_ba;
    bus.sd_addr  = lat_addr;
    bus.sd_din   = lat_din;
    bus.sd_mask  = lat_mask;

    bus.ba_ack   = (hit_ack && !gnt_prog) ? (4'b0001 << gnt_ba) : 4'b0000;
    bus.ba_dst   = (hit_dst && !gnt_prog) ? (4'b0001 << gnt_ba) : 4'b0000;
    bus.ba_rdy   = (hit_rdy && !gnt_prog) ? (4'b0001 << gnt_ba) : 4'b0000;
    bus.prog_ack = hit_ack && gnt_prog;
    bus.prog_rdy = hit_rdy && gnt_prog;
  end
endmodule
